// File: rtl/handshake_pkg.sv
// Shared types and sizing helpers for the handshake FIFO.
package handshake_pkg;

  localparam int unsigned ValueBitsDefault = 8;

  typedef logic [ValueBitsDefault-1:0] value_t;

  // Bits needed to hold an occupancy in the range 0..depth inclusive.
  function automatic int unsigned level_bits(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address depth entries; a single entry still needs one bit.
  function automatic int unsigned ptr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// Storage array for the handshake FIFO: one synchronous write port, one
// asynchronous read port, no reset on the contents.
module handshake_fifo_mem
  import handshake_pkg::*;
#(
  parameter int unsigned VALUE_BITS = ValueBitsDefault,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned PtrW      = ptr_bits(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [PtrW-1:0]       waddr_i,
  input  logic [VALUE_BITS-1:0] wdata_i,
  input  logic [PtrW-1:0]       raddr_i,
  output logic [VALUE_BITS-1:0] rdata_o
);

  logic [VALUE_BITS-1:0] mem_q [DEPTH];

  // Write the selected entry on a push.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Head entry is read combinationally so it is visible the cycle after the push.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/handshake_fifo.sv
// Valid/ready elastic buffer. Both handshake flags are registered so neither
// side sees a combinational path from the other.
module handshake_fifo
  import handshake_pkg::*;
#(
  parameter int unsigned VALUE_BITS = ValueBitsDefault,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned LevelW    = level_bits(DEPTH),
  localparam int unsigned PtrW      = ptr_bits(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [VALUE_BITS-1:0] i_value,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [VALUE_BITS-1:0] o_value,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [LevelW-1:0]     o_level
);

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0]     count_q, count_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic                  push, pop;
  logic [VALUE_BITS-1:0] rdata;

  assign push = i_valid && ready_q;
  assign pop  = valid_q && i_ready;

  // Next-state for pointers, occupancy and the registered handshake flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      // Explicit wrap so non-power-of-two depths work.
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + LevelW'(push) - LevelW'(pop);
    ready_d = (count_d < LevelW'(DEPTH));
    valid_d = (count_d != '0);
  end

  // Control state; storage contents are deliberately left unreset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
    end
  end

  handshake_fifo_mem #(
    .VALUE_BITS (VALUE_BITS),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk_i   (clock),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_value),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // Outputs; the head value is forced to zero while nothing is buffered.
  always_comb begin
    o_ready = ready_q;
    o_valid = valid_q;
    o_level = count_q;
    o_value = valid_q ? rdata : '0;
  end

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge clock) disable iff (!reset_n)
    count_q <= LevelW'(DEPTH));
  a_hold_stable : assert property (@(posedge clock) disable iff (!reset_n)
    (o_valid && !i_ready) |=> $stable(o_value));
  a_no_push_full : assert property (@(posedge clock) disable iff (!reset_n)
    (count_q == LevelW'(DEPTH)) |-> !push);
`endif

endmodule

// File: doc/handshake_fifo.md
Name: handshake_fifo

Overview:
- Valid/ready elastic buffer, the device under test driven by the handshake interface on both sides.
- Input side accepts values on i_value/i_valid and answers with o_ready.
- Output side presents buffered values on o_value/o_valid and is released by downstream i_ready.
- Decouples producer and consumer stalls; preserves strict FIFO order with no loss or duplication.

Parameters:
- VALUE_BITS, 8, width of each transferred value.
- DEPTH, 4, number of storage entries. Legal range is 2..256 and need not be a power of two.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous active-low reset.
- i_value  input  VALUE_BITS  upstream data.
- i_valid  input  1  upstream valid.
- o_ready  output  1  block can accept; push occurs when i_valid && o_ready at posedge.
- o_value  output  VALUE_BITS  head-of-queue data.
- o_valid  output  1  head entry present; pop occurs when o_valid && i_ready at posedge.
- i_ready  input  1  downstream ready.
- o_level  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset, asynchronous on reset_n low:
  - Pointers, count and o_level = 0.
  - o_valid = 0, o_ready = 0, o_value = '0.
  - Storage array is not reset.
- push = i_valid && o_ready; pop = o_valid && i_ready; both are evaluated at the same posedge.
- count_next = count + push - pop. o_level is registered and always equals count.
- o_ready is a flop:
  - next value = (count_next < DEPTH);
  - after reset release it rises on the first posedge;
  - it has no combinational path from i_ready or i_valid.
- o_valid is a flop: next value = (count_next != 0). It has no combinational path from inputs.
- o_value = mem[rd_ptr] when o_valid = 1, else '0 (forced zero).
- Latency: a value pushed at edge N gives o_valid = 1 after edge N when the queue was empty, so it is visible in cycle N+1.
- Full (count == DEPTH):
  - o_ready = 0, so no push can occur even if a pop happens at the same edge;
  - after a pop, o_ready returns to 1 after that edge.
- Empty: o_valid = 0. A push at the same edge as an empty-state i_ready does not pop.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Wrap-around: wr_ptr and rd_ptr increment modulo DEPTH (reset to 0 after DEPTH-1). Compare against DEPTH-1, not bit overflow.
- i_value is sampled only on push. Changes while o_ready = 0 are ignored.
- Reset mid-operation: all buffered entries are discarded immediately. o_valid and o_ready drop within the reset assertion and no stale data appears afterward.
- Throughput: one push and one pop per cycle sustained when neither side stalls and 0 < count < DEPTH.
- Assertions in RTL (simulation only):
  - count <= DEPTH;
  - o_value stable while o_valid && !i_ready;
  - no push when count == DEPTH.

Decomposition:
- handshake_pkg holds the value_t typedef parameterised via VALUE_BITS default, plus a level-width helper function.
- One sub-module, handshake_fifo_mem:
  - DEPTH x VALUE_BITS register array;
  - write port (we, waddr, wdata);
  - asynchronous read port (raddr, rdata);
  - no reset.
- Control (pointers, count, flags) stays in handshake_fifo.

Test Plan:
1. Reset then idle 5 cycles -> o_valid = 0, o_ready = 1 from the first posedge after release, o_level = 0, o_value = 0.
2. Push 8'hA5 with i_ready held 0 -> o_valid = 1 in the next cycle with o_value = 8'hA5 and o_level = 1. o_value stays 8'hA5 while i_ready = 0; raising i_ready for one edge pops it and gives o_level = 0.
3. DEPTH = 4, push 1, 2, 3, 4 with i_ready = 0 -> o_ready = 0 after the 4th push and o_level = 4. A 5th value held on i_valid is not accepted; one pop yields 1 and o_ready = 1 on the next cycle, then the 5th value is accepted.
4. Random stall test:
   - stimulus: the interface valid/ready tasks with MAX_DELAY = 10, 200 sequential values 0..199;
   - required: output sequence exactly 0..199 in order, with no drops or duplicates.
5. Continuous i_valid = i_ready = 1 after the first push -> one value per cycle, o_level constant at 1. Pointers wrap past DEPTH-1 at least 3 times with correct order.
6. Push 3 values, assert reset_n low mid-cycle for 2 cycles -> o_valid and o_ready go low immediately and o_level = 0. After release, the next pushed value 8'h3C is the first value output.
